// File: rtl/fnd_pkg.sv
// Shared FND definitions: blank pattern, active-low 7-seg digit codes (bit 7 = dp) and arbiter states.
package fnd_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;

  typedef enum logic [1:0] {
    BLANK,
    BANNER,
    SHOW
  } fnd_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fnd_digit_decoder.sv
// Decimal digit to active-low 7-seg code with dp off; values above 9 show blank.
// Latency: combinational, no backpressure.
module fnd_digit_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] value,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (value)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/fnd_source_select.sv
// FND source arbiter: picks one of NUM_SRC displays with blank gap and index banner on every switch.
// Latency: 1 cycle registered outputs; no backpressure, switch events outside SHOW are dropped.
module fnd_source_select
  import fnd_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int COM_W      = 4,
  parameter int SEG_W      = 8,
  parameter int BLANK_CYC  = 100_000,
  parameter int BANNER_CYC = 50_000_000,
  parameter int ROTATE_CYC = 300_000_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_SRC*COM_W-1:0]     src_com,
  input  logic [NUM_SRC*SEG_W-1:0]     src_data,
  input  logic [NUM_SRC-1:0]           src_en,
  input  logic                         btn_next,
  input  logic                         sel_req_valid,
  input  logic [$clog2(NUM_SRC)-1:0]   sel_req,
  input  logic                         auto_en,
  output logic [COM_W-1:0]             fnd_com,
  output logic [SEG_W-1:0]             fnd_data,
  output logic [$clog2(NUM_SRC)-1:0]   active_sel,
  output logic                         switching
);

  localparam int SEL_W   = $clog2(NUM_SRC);
  localparam int CNT_MAX = max3(BLANK_CYC, BANNER_CYC, ROTATE_CYC);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] BANNER_LAST = CNT_W'((BANNER_CYC > 0) ? BANNER_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] ROT_LAST    = CNT_W'(ROTATE_CYC - 1);

  fnd_state_t         state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [SEL_W-1:0]   sel_nxt;
  logic [COM_W-1:0]   com_nxt;
  logic [SEG_W-1:0]   data_nxt;
  logic [7:0]         banner_seg;
  logic [SEG_W-1:0]   banner_data;
  logic               req_ok;
  logic               rot_tick;
  logic               nxt_found;
  logic [SEL_W-1:0]   nxt_idx;

  // Nearest enabled index above cur, wrapping; cur itself is never a candidate.
  function automatic logic [SEL_W:0] next_enabled(input logic [SEL_W-1:0] cur,
                                                   input logic [NUM_SRC-1:0] en);
    logic             found;
    logic [SEL_W-1:0] idx;
    int               cand;
    found = 1'b0;
    idx   = cur;
    for (int k = NUM_SRC - 1; k >= 1; k--) begin
      cand = (int'(cur) + k) % NUM_SRC;
      if (en[cand]) begin
        found = 1'b1;
        idx   = SEL_W'(cand);
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    {nxt_found, nxt_idx} = next_enabled(active_sel, src_en);
  end

  assign req_ok = sel_req_valid && (int'(sel_req) < NUM_SRC) &&
                  src_en[sel_req] && (sel_req != active_sel);
  assign rot_tick = (state == SHOW) && auto_en && (cnt == ROT_LAST);

  always_comb begin
    state_nxt = state;
    sel_nxt   = active_sel;
    cnt_nxt   = cnt + CNT_W'(1);
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          cnt_nxt   = '0;
          state_nxt = (BANNER_CYC == 0) ? SHOW : BANNER;
        end
      end
      BANNER: begin
        if (cnt == BANNER_LAST) begin
          cnt_nxt   = '0;
          state_nxt = SHOW;
        end
      end
      SHOW: begin
        // In SHOW the counter is the auto-rotate dwell timer.
        if (!auto_en || rot_tick) cnt_nxt = '0;
        if (req_ok) begin
          state_nxt = BLANK;
          sel_nxt   = sel_req;
          cnt_nxt   = '0;
        end else if (nxt_found && (btn_next || rot_tick || !src_en[active_sel])) begin
          state_nxt = BLANK;
          sel_nxt   = nxt_idx;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = BLANK;
        cnt_nxt   = '0;
      end
    endcase
  end

  fnd_digit_decoder u_banner_dec (
    .value (4'(sel_nxt)),
    .seg   (banner_seg)
  );

  // Widen by inverting so any segment bits beyond the 8-bit code stay off.
  assign banner_data = ~(SEG_W'(~banner_seg));

  // Output register is loaded from the next state so a switch blanks on the accepting edge.
  always_comb begin
    com_nxt  = '1;
    data_nxt = '1;
    case (state_nxt)
      BANNER: begin
        com_nxt  = ~COM_W'(1);
        data_nxt = banner_data;
      end
      SHOW: begin
        if (src_en[sel_nxt]) begin
          com_nxt  = src_com[int'(sel_nxt)*COM_W +: COM_W];
          data_nxt = src_data[int'(sel_nxt)*SEG_W +: SEG_W];
        end
      end
      default: begin
        com_nxt  = '1;
        data_nxt = '1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BLANK;
      cnt        <= '0;
      active_sel <= '0;
      fnd_com    <= '1;
      fnd_data   <= '1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      active_sel <= sel_nxt;
      fnd_com    <= com_nxt;
      fnd_data   <= data_nxt;
    end
  end

  assign switching = (state != SHOW);

endmodule
